// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: datapath width, canonical NOP and fetch FSM states.
package riscv_pipe_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/if_inst_buffer.sv
// One-entry instruction+PC holding register used when a response lands during a stall.
module if_inst_buffer
    import riscv_pipe_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            clear,
    input  logic [XLEN-1:0] instr_in,
    input  logic [XLEN-1:0] pc_in,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic            valid
);

    // clear wins over load so a flush can never leave a stale entry behind
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr <= '0;
            pc    <= '0;
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            instr <= instr_in;
            pc    <= pc_in;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: single-outstanding request/grant/rvalid memory port feeding the IF/ID register.
module if_fetch_stage
    import riscv_pipe_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = riscv_pipe_pkg::NOP_INSTR
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall_IF,
    input  logic                   flush_IF,
    input  logic signed [XLEN-1:0] branch_target,
    output logic                   imem_req,
    output logic        [XLEN-1:0] imem_addr,
    input  logic                   imem_gnt,
    input  logic                   imem_rvalid,
    input  logic        [XLEN-1:0] imem_rdata,
    output logic        [XLEN-1:0] Instruc_IFID,
    output logic signed [XLEN-1:0] PC_IFID
);

    fetch_state_e    state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic [XLEN-1:0] pc_inflight, pc_inflight_nxt;
    logic            ifid_we;
    logic [XLEN-1:0] ifid_instr_nxt, ifid_pc_nxt;
    logic            buf_load, buf_clear, buf_valid;
    logic [XLEN-1:0] buf_instr, buf_pc;

    if_inst_buffer u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (buf_load),
        .clear    (buf_clear),
        .instr_in (imem_rdata),
        .pc_in    (pc_inflight),
        .instr    (buf_instr),
        .pc       (buf_pc),
        .valid    (buf_valid)
    );

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        pc_inflight_nxt = pc_inflight;
        ifid_we         = !stall_IF;
        ifid_instr_nxt  = NOP_INSTR;
        ifid_pc_nxt     = '0;
        buf_load        = 1'b0;
        buf_clear       = 1'b0;
        imem_req        = (state == FETCH);
        imem_addr       = pc;

        case (state)
            FETCH: begin
                if (imem_gnt) begin
                    pc_inflight_nxt = pc;
                    pc_nxt          = pc + 32'd4;
                    state_nxt       = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (stall_IF) begin
                        buf_load  = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        ifid_instr_nxt = imem_rdata;
                        ifid_pc_nxt    = pc_inflight;
                        state_nxt      = FETCH;
                    end
                end
            end
            HOLD: begin
                if (!stall_IF) begin
                    if (buf_valid) begin
                        ifid_instr_nxt = buf_instr;
                        ifid_pc_nxt    = buf_pc;
                    end
                    buf_clear = 1'b1;
                    state_nxt = FETCH;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase

        // Flush overrides everything above; the state choice depends on whether
        // a response is still owed by memory and must be swallowed in DROP.
        if (flush_IF) begin
            ifid_we        = 1'b1;
            ifid_instr_nxt = NOP_INSTR;
            ifid_pc_nxt    = '0;
            pc_nxt         = branch_target;
            buf_load       = 1'b0;
            buf_clear      = 1'b1;
            case (state)
                FETCH:   state_nxt = imem_gnt ? DROP : FETCH;
                WAIT:    state_nxt = imem_rvalid ? FETCH : DROP;
                HOLD:    state_nxt = FETCH;
                DROP:    state_nxt = imem_rvalid ? FETCH : DROP;
                default: state_nxt = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            pc_inflight  <= '0;
            Instruc_IFID <= NOP_INSTR;
            PC_IFID      <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            pc_inflight <= pc_inflight_nxt;
            if (ifid_we) begin
                Instruc_IFID <= ifid_instr_nxt;
                PC_IFID      <= ifid_pc_nxt;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: transaction-level reference model, directed scenarios and random traffic.
module tb_if_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               stall_IF, flush_IF;
    logic signed [31:0] branch_target;
    logic               imem_req;
    logic        [31:0] imem_addr;
    logic               imem_gnt, imem_rvalid;
    logic        [31:0] imem_rdata;
    logic        [31:0] Instruc_IFID;
    logic signed [31:0] PC_IFID;

    if_fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_IF      (stall_IF),
        .flush_IF      (flush_IF),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .Instruc_IFID  (Instruc_IFID),
        .PC_IFID       (PC_IFID)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: next address, whether a response is owed, whether that
    // response is to be thrown away, and an optional parked instruction.
    logic [31:0] m_next, m_inflight, m_held_i, m_held_pc, m_ifid_i, m_ifid_pc;
    bit          m_busy, m_poison, m_held_v;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    function void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function void model_reset();
        m_next    = RST_PC;
        m_inflight = '0;
        m_busy    = 0;
        m_poison  = 0;
        m_held_v  = 0;
        m_held_i  = '0;
        m_held_pc = '0;
        m_ifid_i  = NOP;
        m_ifid_pc = '0;
    endfunction

    function bit model_req();
        return !m_busy && !m_held_v;
    endfunction

    function void model_step();
        bit granted, arrive, delivered;
        if (!rst_n) begin
            model_reset();
            return;
        end
        granted   = model_req() && imem_gnt;
        arrive    = m_busy && imem_rvalid;
        delivered = 0;
        if (flush_IF) begin
            m_ifid_i  = NOP;
            m_ifid_pc = '0;
            m_held_v  = 0;
            m_next    = branch_target;
            if (granted) begin
                m_busy   = 1;
                m_poison = 1;
            end else if (arrive) begin
                m_busy   = 0;
                m_poison = 0;
            end else if (m_busy) begin
                m_poison = 1;
            end
        end else begin
            if (granted) begin
                m_inflight = m_next;
                m_next     = m_next + 32'd4;
                m_busy     = 1;
            end else if (arrive) begin
                m_busy = 0;
                if (m_poison) begin
                    m_poison = 0;
                end else if (stall_IF) begin
                    m_held_i  = imem_rdata;
                    m_held_pc = m_inflight;
                    m_held_v  = 1;
                end else begin
                    m_ifid_i  = imem_rdata;
                    m_ifid_pc = m_inflight;
                    delivered = 1;
                end
            end else if (m_held_v && !stall_IF) begin
                m_ifid_i  = m_held_i;
                m_ifid_pc = m_held_pc;
                m_held_v  = 0;
                delivered = 1;
            end
            if (!stall_IF && !delivered) begin
                m_ifid_i  = NOP;
                m_ifid_pc = '0;
            end
        end
    endfunction

    task automatic compare_model();
        bit er;
        er = model_req();
        check("model_req", {31'd0, imem_req}, {31'd0, er});
        if (er) check("model_addr", imem_addr, m_next);
        check("model_ifid_instr", Instruc_IFID, m_ifid_i);
        check("model_ifid_pc", PC_IFID, m_ifid_pc);
    endtask

    // Inputs change just after a falling edge; the model advances and is compared at the next falling edge.
    task automatic cycle(input bit st, input bit fl, input logic [31:0] tgt,
                         input bit gn, input bit rv, input logic [31:0] rd);
        stall_IF      = st;
        flush_IF      = fl;
        branch_target = tgt;
        imem_gnt      = gn;
        imem_rvalid   = rv;
        imem_rdata    = rd;
        @(posedge clk);
        @(negedge clk);
        model_step();
        compare_model();
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        model_reset();
        cycle(0, 0, '0, 0, 0, '0);
        rst_n = 1'b1;
    endtask

    task automatic idle();
        cycle(0, 0, '0, 0, 0, '0);
    endtask

    initial begin
        bit          pend;
        int unsigned cnt;
        logic [31:0] paddr, tgt, rd;
        bit          st, fl, gn, rv;

        rst_n = 1'b0;
        stall_IF = 0; flush_IF = 0; branch_target = '0;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
        model_reset();
        @(negedge clk);
        cycle(0, 0, '0, 0, 0, '0);
        check("reset_instr", Instruc_IFID, NOP);
        check("reset_pc", PC_IFID, 32'h0);
        rst_n = 1'b1;
        #1;
        check("reset_req", {31'd0, imem_req}, 32'd1);
        check("reset_addr", imem_addr, RST_PC);

        // straight-line fetch, 1-cycle memory
        cycle(0, 0, '0, 1, 0, '0);
        check("seq_req_wait", {31'd0, imem_req}, 32'd0);
        cycle(0, 0, '0, 0, 1, memword(32'h0));
        check("seq_ifid0_pc", PC_IFID, 32'h0);
        check("seq_ifid0_instr", Instruc_IFID, memword(32'h0));
        check("seq_addr4", imem_addr, 32'h4);
        cycle(0, 0, '0, 1, 0, '0);
        check("seq_bubble", Instruc_IFID, NOP);
        cycle(0, 0, '0, 0, 1, memword(32'h4));
        check("seq_ifid4_pc", PC_IFID, 32'h4);
        check("seq_addr8", imem_addr, 32'h8);
        cycle(0, 0, '0, 1, 0, '0);

        // flush while waiting for PC 8, then the stale response arrives
        cycle(0, 1, 32'h40, 0, 0, '0);
        check("flw_req", {31'd0, imem_req}, 32'd0);
        check("flw_ifid", Instruc_IFID, NOP);
        cycle(0, 0, '0, 0, 1, memword(32'h8));
        check("flw_drop_ifid", Instruc_IFID, NOP);
        check("flw_addr", imem_addr, 32'h40);

        // flush coincident with rvalid
        cycle(0, 0, '0, 1, 0, '0);
        cycle(0, 1, 32'h80, 0, 1, memword(32'h40));
        check("flrv_ifid", Instruc_IFID, NOP);
        check("flrv_req", {31'd0, imem_req}, 32'd1);
        check("flrv_addr", imem_addr, 32'h80);

        // stall while the PC 4 word returns
        reset_pulse();
        cycle(0, 0, '0, 1, 0, '0);
        cycle(0, 0, '0, 0, 1, memword(32'h0));
        cycle(0, 0, '0, 1, 0, '0);
        cycle(1, 0, '0, 0, 1, 32'h0050_0093);
        check("stall_req1", {31'd0, imem_req}, 32'd0);
        check("stall_hold1", Instruc_IFID, NOP);
        cycle(1, 0, '0, 0, 0, '0);
        cycle(1, 0, '0, 0, 0, '0);
        check("stall_req3", {31'd0, imem_req}, 32'd0);
        check("stall_hold3", Instruc_IFID, NOP);
        idle();
        check("stall_rel_instr", Instruc_IFID, 32'h0050_0093);
        check("stall_rel_pc", PC_IFID, 32'h4);
        check("stall_rel_addr", imem_addr, 32'h8);

        // flush and stall together while holding
        cycle(0, 0, '0, 1, 0, '0);
        cycle(1, 0, '0, 0, 1, memword(32'h8));
        cycle(1, 1, 32'h100, 0, 0, '0);
        check("hold_fl_ifid", Instruc_IFID, NOP);
        check("hold_fl_addr", imem_addr, 32'h100);
        idle();
        check("hold_fl_cleared", Instruc_IFID, NOP);

        // address wrap at the top of memory
        cycle(0, 1, 32'hFFFF_FFFC, 0, 0, '0);
        check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
        cycle(0, 0, '0, 1, 0, '0);
        cycle(0, 0, '0, 0, 1, memword(32'hFFFF_FFFC));
        check("wrap_ifid_pc", PC_IFID, 32'hFFFF_FFFC);
        check("wrap_addr_next", imem_addr, 32'h0);

        // reset in WAIT, then a late response
        cycle(0, 0, '0, 1, 0, '0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rstw_instr", Instruc_IFID, NOP);
        check("rstw_req", {31'd0, imem_req}, 32'd1);
        check("rstw_addr", imem_addr, RST_PC);
        cycle(0, 0, '0, 0, 0, '0);
        rst_n = 1'b1;
        cycle(0, 0, '0, 0, 1, 32'hDEAD_BEEF);
        check("late_rv_ifid", Instruc_IFID, NOP);
        check("late_rv_addr", imem_addr, RST_PC);

        // random traffic against the model
        pend = 0;
        cnt  = 0;
        paddr = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                pend = 0;
                reset_pulse();
                continue;
            end
            rv = 0;
            rd = $urandom;
            if (pend) begin
                if (cnt == 0) begin
                    rv   = 1;
                    rd   = memword(paddr);
                    pend = 0;
                end else begin
                    cnt--;
                end
            end
            gn = imem_req && ($urandom_range(0, 3) != 0);
            if (gn) begin
                pend  = 1;
                cnt   = $urandom_range(0, 2);
                paddr = imem_addr;
            end
            st = ($urandom_range(0, 2) == 0);
            fl = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0)
                tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
            else
                tgt = $urandom & 32'hFFFF_FFFC;
            cycle(st, fl, tgt, gn, rv, rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
